// File: rtl/bm_sym_decoder_pkg.sv
// Shared definitions for the complement-coded symbol decoder: default geometry
// and FSM state encoding.
package bm_sym_decoder_pkg;

  localparam int DEF_BITS       = 2;
  localparam int DEF_SYMS       = 4;
  localparam int DEF_FIFO_DEPTH = 4;

  typedef enum logic {
    ST_ASSEMBLE = 1'b0,
    ST_PARITY   = 1'b1
  } state_t;

endpackage

// File: rtl/bm_sym_fifo.sv
// Word FIFO for the symbol decoder: synchronous push/pop, async active-low reset,
// occupancy level and combinational head (zero when empty).
module bm_sym_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  head,
  output logic [LW-1:0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [LW-1:0] level_r;

  // Storage, pointers (wrapping modulo DEPTH) and occupancy.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {W{1'b0}};
      end
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {LW{1'b0}};
    end else begin
      if (push) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (pop) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push, pop})
        2'b10:   level_r <= level_r + LW'(1);
        2'b01:   level_r <= level_r - LW'(1);
        default: level_r <= level_r;
      endcase
    end
  end

  assign head  = (level_r == {LW{1'b0}}) ? {W{1'b0}} : mem_r[rd_ptr_r];
  assign level = level_r;

endmodule

// File: rtl/bm_sym_decoder.sv
// Complement-coded symbol decoder: packs SYMS decoded symbols LSB-first into a
// word and queues it in a FIFO. Optional trailing parity symbol: BM_SYM_PARITY_EN.
module bm_sym_decoder
  import bm_sym_decoder_pkg::*;
#(
  parameter int BITS       = DEF_BITS,
  parameter int SYMS       = DEF_SYMS,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [BITS-1:0]               sym_in,
  input  logic                          sym_valid,
  output logic                          sym_ready,
  output logic [BITS*SYMS-1:0]          word_out,
  output logic                          word_valid,
  input  logic                          word_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          err_parity
);

  localparam int W  = BITS * SYMS;
  localparam int IW = (SYMS > 1) ? $clog2(SYMS) : 1;
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  state_t          state_r, state_nxt_s;
  logic [IW-1:0]   idx_r, idx_nxt_s;
  logic [W-1:0]    asm_r, asm_nxt_s;
  logic            err_r, err_nxt_s;
  logic            push_s, pop_s, accept_s;
  logic [W-1:0]    push_data_s;
  logic [W-1:0]    head_s;
  logic [LW-1:0]   level_s;
  logic [BITS-1:0] dec_s;

  assign dec_s     = ~sym_in;
  assign sym_ready = (level_s != LW'(FIFO_DEPTH));
  assign accept_s  = sym_valid & sym_ready;
  assign pop_s     = word_valid & word_ready;

`ifdef BM_SYM_PARITY_EN
  logic [BITS-1:0] parity_s;

  // Expected parity symbol: XOR of all assembled data symbols.
  always_comb begin
    parity_s = {BITS{1'b0}};
    for (int k = 0; k < SYMS; k++) begin
      parity_s = parity_s ^ asm_r[k*BITS +: BITS];
    end
  end
`endif

  // Next-state, index/assembly update and FIFO push decision.
  always_comb begin
    state_nxt_s = state_r;
    idx_nxt_s   = idx_r;
    asm_nxt_s   = asm_r;
    err_nxt_s   = 1'b0;
    push_s      = 1'b0;
    push_data_s = asm_r;
    case (state_r)
      ST_ASSEMBLE: begin
        if (accept_s) begin
          asm_nxt_s[idx_r*BITS +: BITS] = dec_s;
          if (idx_r == IW'(SYMS - 1)) begin
            idx_nxt_s = {IW{1'b0}};
`ifdef BM_SYM_PARITY_EN
            state_nxt_s = ST_PARITY;
`else
            push_s      = 1'b1;
            push_data_s = {dec_s, asm_r[W-BITS-1:0]};
`endif
          end else begin
            idx_nxt_s = idx_r + IW'(1);
          end
        end else begin
          idx_nxt_s = idx_r;
        end
      end
      ST_PARITY: begin
`ifdef BM_SYM_PARITY_EN
        if (accept_s) begin
          push_s      = 1'b1;
          err_nxt_s   = (parity_s != dec_s);
          state_nxt_s = ST_ASSEMBLE;
        end else begin
          state_nxt_s = ST_PARITY;
        end
`else
        state_nxt_s = ST_ASSEMBLE;
`endif
      end
      default: state_nxt_s = ST_ASSEMBLE;
    endcase
  end

  // FSM, symbol index, assembly and parity-error registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_ASSEMBLE;
      idx_r   <= {IW{1'b0}};
      asm_r   <= {W{1'b0}};
      err_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      idx_r   <= idx_nxt_s;
      asm_r   <= asm_nxt_s;
      err_r   <= err_nxt_s;
    end
  end

  bm_sym_fifo #(
    .W     (W),
    .DEPTH (FIFO_DEPTH),
    .LW    (LW)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (push_s),
    .pop     (pop_s),
    .din     (push_data_s),
    .head    (head_s),
    .level   (level_s)
  );

  assign word_out   = head_s;
  assign word_valid = (level_s != {LW{1'b0}});
  assign fifo_level = level_s;
  assign err_parity = err_r;

endmodule

// File: tb/tb_bm_sym_decoder.sv
// Directed bench for bm_sym_decoder (BITS=2, SYMS=4, FIFO_DEPTH=4); the parity
// step is built only when BM_SYM_PARITY_EN is defined.
module tb_bm_sym_decoder;

  logic       clock;
  logic       reset_n;
  logic [1:0] sym_in;
  logic       sym_valid;
  logic       sym_ready;
  logic [7:0] word_out;
  logic       word_valid;
  logic       word_ready;
  logic [2:0] fifo_level;
  logic       err_parity;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_q [4];
  logic [7:0] w5;
  logic [7:0] wc;
  logic [1:0] last_sym;

  bm_sym_decoder dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .sym_in     (sym_in),
    .sym_valid  (sym_valid),
    .sym_ready  (sym_ready),
    .word_out   (word_out),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .fifo_level (fifo_level),
    .err_parity (err_parity)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one symbol and hold it until the accept edge (bounded wait).
  task automatic send(input logic [1:0] s);
    int cnt;
    cnt = 0;
    sym_in    = s;
    sym_valid = 1'b1;
    while (sym_ready !== 1'b1 && cnt < 50) begin
      @(negedge clock);
      cnt++;
    end
    chk("sym_ready_at_send", {31'b0, sym_ready}, 32'd1);
    @(posedge clock);
    @(negedge clock);
  endtask

  function automatic logic [1:0] par_sym(input logic [7:0] d);
    return ~(d[1:0] ^ d[3:2] ^ d[5:4] ^ d[7:6]);
  endfunction

  task automatic send_word(input logic [7:0] d);
    for (int k = 0; k < 4; k++) begin
      send(~d[2*k +: 2]);
    end
`ifdef BM_SYM_PARITY_EN
    send(par_sym(d));
`endif
    sym_valid = 1'b0;
  endtask

  task automatic step;
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    // 1: reset held with sym_valid asserted
    reset_n    = 1'b0;
    sym_in     = 2'b00;
    sym_valid  = 1'b1;
    word_ready = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_word_valid", {31'b0, word_valid}, 32'd0);
    chk("rst_word_out", {24'b0, word_out}, 32'h00);
    chk("rst_level", {29'b0, fifo_level}, 32'd0);
    chk("rst_sym_ready", {31'b0, sym_ready}, 32'd1);
    chk("rst_err", {31'b0, err_parity}, 32'd0);
    reset_n   = 1'b1;
    sym_valid = 1'b0;
    step();
    step();
    chk("post_rst_word_valid", {31'b0, word_valid}, 32'd0);
    chk("post_rst_level", {29'b0, fifo_level}, 32'd0);

    // 2: decode 11,10,01,00 -> E4 with one-cycle latency
    word_ready = 1'b1;
    send(2'b11);
    send(2'b10);
    send(2'b01);
    chk("dec_valid_early", {31'b0, word_valid}, 32'd0);
    send(2'b00);
`ifdef BM_SYM_PARITY_EN
    send(2'b11);
`endif
    sym_valid = 1'b0;
    chk("dec_valid", {31'b0, word_valid}, 32'd1);
    chk("dec_word", {24'b0, word_out}, 32'hE4);
    chk("dec_level", {29'b0, fifo_level}, 32'd1);
    step();
    chk("dec_valid_drop", {31'b0, word_valid}, 32'd0);
    chk("dec_word_empty", {24'b0, word_out}, 32'h00);

    // 3: backpressure, FIFO full, 5th word stalls
    word_ready = 1'b0;
    send_word(8'h1B);
    send_word(8'hC6);
    send_word(8'h72);
    send_word(8'hA5);
    chk("bp_level_full", {29'b0, fifo_level}, 32'd4);
    chk("bp_sym_ready_low", {31'b0, sym_ready}, 32'd0);
    chk("bp_head", {24'b0, word_out}, 32'h1B);
    w5        = 8'h3C;
    sym_in    = ~w5[1:0];
    sym_valid = 1'b1;
    step();
    step();
    chk("bp_stall_level", {29'b0, fifo_level}, 32'd4);
    chk("bp_stall_ready", {31'b0, sym_ready}, 32'd0);
    sym_valid  = 1'b0;
    word_ready = 1'b1;
    chk("bp_out0", {24'b0, word_out}, 32'h1B);
    step();
    word_ready = 1'b0;
    chk("bp_level_after_pop", {29'b0, fifo_level}, 32'd3);
    send_word(w5);
    chk("bp_level_refill", {29'b0, fifo_level}, 32'd4);
    exp_q = '{8'hC6, 8'h72, 8'hA5, 8'h3C};
    word_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("bp_out_valid", {31'b0, word_valid}, 32'd1);
      chk("bp_out_word", {24'b0, word_out}, {24'b0, exp_q[i]});
      step();
    end
    chk("bp_drained_level", {29'b0, fifo_level}, 32'd0);
    chk("bp_drained_valid", {31'b0, word_valid}, 32'd0);

    // 4: simultaneous push and pop at level 2
    word_ready = 1'b0;
    send_word(8'h5A);
    send_word(8'h96);
    chk("sim_level2", {29'b0, fifo_level}, 32'd2);
    wc = 8'h0F;
    send(~wc[1:0]);
    send(~wc[3:2]);
    send(~wc[5:4]);
`ifdef BM_SYM_PARITY_EN
    send(~wc[7:6]);
    last_sym = par_sym(wc);
`else
    last_sym = ~wc[7:6];
`endif
    sym_in     = last_sym;
    sym_valid  = 1'b1;
    word_ready = 1'b1;
    chk("sim_head_before", {24'b0, word_out}, 32'h5A);
    step();
    sym_valid = 1'b0;
    chk("sim_level_kept", {29'b0, fifo_level}, 32'd2);
    chk("sim_head_second", {24'b0, word_out}, 32'h96);
    step();
    chk("sim_head_third", {24'b0, word_out}, 32'h0F);
    chk("sim_level1", {29'b0, fifo_level}, 32'd1);
    step();
    chk("sim_level0", {29'b0, fifo_level}, 32'd0);
    word_ready = 1'b0;

    // 5: reset in the middle of a word discards it
    send(2'b01);
    send(2'b10);
    sym_valid = 1'b0;
    reset_n   = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    send_word(8'hFF);
    chk("mid_rst_level", {29'b0, fifo_level}, 32'd1);
    chk("mid_rst_word", {24'b0, word_out}, 32'hFF);
    word_ready = 1'b1;
    step();
    chk("mid_rst_level_drained", {29'b0, fifo_level}, 32'd0);
    word_ready = 1'b0;

`ifdef BM_SYM_PARITY_EN
    // 6: parity symbol good, then bad
    word_ready = 1'b1;
    send(2'b11);
    send(2'b10);
    send(2'b01);
    send(2'b00);
    chk("par_wait_valid", {31'b0, word_valid}, 32'd0);
    send(2'b11);
    sym_valid = 1'b0;
    chk("par_good_err", {31'b0, err_parity}, 32'd0);
    chk("par_good_word", {24'b0, word_out}, 32'hE4);
    step();
    chk("par_good_drained", {31'b0, word_valid}, 32'd0);
    send(2'b11);
    send(2'b10);
    send(2'b01);
    send(2'b00);
    send(2'b10);
    sym_valid = 1'b0;
    chk("par_bad_err", {31'b0, err_parity}, 32'd1);
    chk("par_bad_word", {24'b0, word_out}, 32'hE4);
    chk("par_bad_valid", {31'b0, word_valid}, 32'd1);
    step();
    chk("par_bad_err_pulse", {31'b0, err_parity}, 32'd0);
    word_ready = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
